// File: rtl/lcd_msg_arbiter_if.sv
// ----------------------------------------------------------------------------
// lcd_msg_arbiter_if
// Bundles the requester side and the LCD-controller side of the message
// arbiter into one interface.
//   req      : per-requester display request (level)
//   row1_in  : packed row-1 text, requester i at [i*128 +: 128]
//   row2_in  : packed row-2 text, same layout
//   grant    : one-hot current owner, zero when idle
//   owner_id : index of current / most recent owner
//   busy     : high while a message owns the display
//   row_1/2  : text presented to the LCD controller
//   strobe   : one-cycle pulse when row_1/row_2 take a new value
// Modports: master = requesters + LCD side (testbench), slave = arbiter.
// ----------------------------------------------------------------------------
interface lcd_msg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*128-1:0] row1_in;
    logic [NUM_REQ*128-1:0] row2_in;
    logic [NUM_REQ-1:0]     grant;
    logic [2:0]             owner_id;
    logic                   busy;
    logic [127:0]           row_1;
    logic [127:0]           row_2;
    logic                   strobe;

    modport master (
        output req, row1_in, row2_in,
        input  grant, owner_id, busy, row_1, row_2, strobe
    );

    modport slave (
        input  req, row1_in, row2_in,
        output grant, owner_id, busy, row_1, row_2, strobe
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_msg_arbiter
// Shares one 2x16 character LCD controller between NUM_REQ message sources.
// Round-robin grant, with a minimum dwell of MIN_HOLD cycles per granted
// message so every message stays readable.
// Ports:
//   clk : system clock
//   rst : synchronous, active-low reset
//   bus : lcd_msg_arbiter_if.slave (req/row inputs, grant/owner/busy,
//         row_1/row_2/strobe towards the LCD controller)
// ----------------------------------------------------------------------------
module lcd_msg_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter int         MIN_HOLD   = 1_000_000,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    lcd_msg_arbiter_if.slave  bus
);
    localparam int                CNT_W     = $clog2(MIN_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MIN_HOLD - 1);
    localparam logic [127:0]      BLANK_ROW = {16{BLANK_CHAR}};

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_reg,  state_next;
    logic [NUM_REQ-1:0] grant_reg,  grant_next;
    logic [2:0]         owner_reg,  owner_next;
    logic [2:0]         ptr_reg,    ptr_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [127:0]       row1_reg,   row1_next;
    logic [127:0]       row2_reg,   row2_next;
    logic               strobe_reg, strobe_next;

    // Requester slots padded out to 8 so a 3-bit index is always in range;
    // unused slots never request and hold blank text.
    logic [127:0] row1_arr [0:7];
    logic [127:0] row2_arr [0:7];
    logic [7:0]   req_pad;
    logic [7:0]   grant_pad;
    logic [7:0]   pick_src;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign row1_arr[gi]  = bus.row1_in[gi*128 +: 128];
                assign row2_arr[gi]  = bus.row2_in[gi*128 +: 128];
                assign req_pad[gi]   = bus.req[gi];
                assign grant_pad[gi] = grant_reg[gi];
            end else begin : g_unused
                assign row1_arr[gi]  = BLANK_ROW;
                assign row2_arr[gi]  = BLANK_ROW;
                assign req_pad[gi]   = 1'b0;
                assign grant_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Candidates exclude the current owner; in IDLE grant_reg is zero so this
    // is simply req.
    assign pick_src = req_pad & ~grant_pad;

    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[2:0];
    endfunction

    // Round-robin search from ptr upward, wrapping at NUM_REQ.
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(ptr_reg, i);
            if (!pick_found && pick_src[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    logic expired;
    logic owner_req;
    logic load_new;

    assign expired   = (cnt_reg == CNT_MAX);
    assign owner_req = req_pad[owner_reg];

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        row1_next   = row1_reg;
        row2_next   = row2_reg;
        strobe_next = 1'b0;
        load_new    = 1'b0;

        case (state_reg)
            IDLE: begin
                grant_next = '0;
                load_new   = pick_found;
            end
            HOLD: begin
                if (!expired) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (expired && pick_found) begin
                    load_new = 1'b1;
                end else if (expired && !owner_req) begin
                    state_next = IDLE;
                    grant_next = '0;
                end else if (owner_req) begin
                    // Live update: follow the owner's text, strobe only on change.
                    row1_next   = row1_arr[owner_reg];
                    row2_next   = row2_arr[owner_reg];
                    strobe_next = (row1_arr[owner_reg] != row1_reg) ||
                                  (row2_arr[owner_reg] != row2_reg);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase

        // A new grant always loads the winner's text and strobes, even if the
        // text happens to match what is already displayed.
        if (load_new) begin
            state_next  = HOLD;
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_next[i] = (pick_idx == 3'(i));
            end
            owner_next  = pick_idx;
            ptr_next    = wrap_idx(pick_idx, 1);
            cnt_next    = '0;
            row1_next   = row1_arr[pick_idx];
            row2_next   = row2_arr[pick_idx];
            strobe_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            owner_reg  <= '0;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            row1_reg   <= BLANK_ROW;
            row2_reg   <= BLANK_ROW;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            row1_reg   <= row1_next;
            row2_reg   <= row2_next;
            strobe_reg <= strobe_next;
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.owner_id = owner_reg;
    assign bus.busy     = (state_reg == HOLD);
    assign bus.row_1    = row1_reg;
    assign bus.row_2    = row2_reg;
    assign bus.strobe   = strobe_reg;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lcd_msg_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the arbiter (NUM_REQ=4, MIN_HOLD=8).
// ----------------------------------------------------------------------------
module tb_lcd_msg_arbiter;
    localparam int           NREQ  = 4;
    localparam int           MHOLD = 8;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic clk;
    logic rst;
    logic [NREQ-1:0] req_drv;
    logic [127:0]    r1 [0:NREQ-1];
    logic [127:0]    r2 [0:NREQ-1];

    int total;
    int bad;

    lcd_msg_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    assign bus.req     = req_drv;
    assign bus.row1_in = {r1[3], r1[2], r1[1], r1[0]};
    assign bus.row2_in = {r2[3], r2[2], r2[1], r2[0]};

    lcd_msg_arbiter #(
        .NUM_REQ   (NREQ),
        .MIN_HOLD  (MHOLD),
        .BLANK_CHAR(8'h20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit           m_active;
    int           m_owner;
    int           m_held;     // cycles elapsed since the grant
    int           m_ptr;
    logic [127:0] m_r1;
    logic [127:0] m_r2;
    logic         m_strobe;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_active = 1'b1;
        m_owner  = w;
        m_held   = 0;
        m_ptr    = (w + 1) % NREQ;
        m_r1     = r1[w];
        m_r2     = r2[w];
        m_strobe = 1'b1;
    endtask

    // Applies the inputs present just before the coming clock edge.
    task automatic model_update();
        logic [NREQ-1:0] others;
        int w;
        m_strobe = 1'b0;
        if (!rst) begin
            m_active = 1'b0;
            m_owner  = 0;
            m_held   = 0;
            m_ptr    = 0;
            m_r1     = BLANK;
            m_r2     = BLANK;
        end else if (!m_active) begin
            w = rr_pick(req_drv, m_ptr);
            if (w >= 0) take(w);
        end else begin
            others = req_drv;
            others[m_owner] = 1'b0;
            if (m_held >= MHOLD - 1 && others != 0) begin
                take(rr_pick(others, m_ptr));
            end else if (m_held >= MHOLD - 1 && !req_drv[m_owner]) begin
                m_active = 1'b0;
            end else begin
                if (req_drv[m_owner]) begin
                    m_strobe = (r1[m_owner] !== m_r1) || (r2[m_owner] !== m_r2);
                    m_r1 = r1[m_owner];
                    m_r2 = r2[m_owner];
                end
                m_held++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [NREQ-1:0] g;
        g = m_active ? NREQ'(1 << m_owner) : '0;
        chk({where, "/grant"},    128'(bus.grant),    128'(g));
        chk({where, "/owner_id"}, 128'(bus.owner_id), 128'(m_owner));
        chk({where, "/busy"},     128'(bus.busy),     128'(m_active));
        chk({where, "/strobe"},   128'(bus.strobe),   128'(m_strobe));
        chk({where, "/row_1"},    bus.row_1,          m_r1);
        chk({where, "/row_2"},    bus.row_2,          m_r2);
        $display("[%0t] %s req=%b grant=%b owner=%0d busy=%b strobe=%b", $time, where,
                 req_drv, bus.grant, bus.owner_id, bus.busy, bus.strobe);
    endtask

    task automatic step(input string where);
        model_update();
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        req_drv = '0;
        for (int i = 0; i < NREQ; i++) begin
            r1[i] = BLANK;
            r2[i] = BLANK;
        end

        // Reset held three cycles, then idle with no requests.
        repeat (3) step("reset");
        rst = 1'b1;
        repeat (4) step("idle");
        chk("reset_row1_blank", bus.row_1, BLANK);
        chk("reset_row2_blank", bus.row_2, BLANK);

        // Single request from requester 2, dropped at cycle 3 of the hold.
        r1[2]   = "HELLO WORLD     ";
        r2[2]   = "line two  2     ";
        req_drv = 4'b0100;
        step("single");
        chk("single_grant", 128'(bus.grant), 128'(4'b0100));
        chk("single_owner", 128'(bus.owner_id), 128'(3'd2));
        step("single");
        step("single");
        req_drv = '0;
        repeat (8) step("single_drop");
        chk("single_row1_kept", bus.row_1, 128'("HELLO WORLD     "));

        // Round-robin contention from a fresh pointer.
        rst = 1'b0;
        step("rr_reset");
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            r1[i] = {"REQ", 8'h30 + 8'(i), "  row one    "};
            r2[i] = {"REQ", 8'h30 + 8'(i), "  row two    "};
        end
        req_drv = 4'b1011;
        repeat (34) step("rr");
        req_drv = '0;
        repeat (9) step("rr_drain");

        // Live update of owner 1's row 2, byte 0.
        rst = 1'b0;
        step("live_reset");
        rst = 1'b1;
        r2[1][7:0] = 8'h30;
        req_drv = 4'b0010;
        repeat (3) step("live");
        r2[1][7:0] = 8'h31;
        step("live_change");
        chk("live_strobe_on", 128'(bus.strobe), 128'(1'b1));
        step("live_same");
        chk("live_strobe_off", 128'(bus.strobe), 128'(1'b0));
        req_drv = '0;
        repeat (8) step("live_drain");

        // Sole owner extends beyond the dwell, then yields immediately.
        req_drv = 4'b1000;
        repeat (30) step("sole");
        req_drv = 4'b1001;
        step("sole_yield");
        chk("sole_yield_grant", 128'(bus.grant), 128'(4'b0001));

        // Reset in the middle of a hold.
        rst = 1'b0;
        step("mid_pre");
        rst = 1'b1;
        req_drv = 4'b1111;
        repeat (5) step("mid_hold");
        rst = 1'b0;
        step("mid_reset");
        chk("mid_reset_grant", 128'(bus.grant), 128'(4'b0000));
        chk("mid_reset_row1", bus.row_1, BLANK);
        rst = 1'b1;
        step("mid_regrant");
        chk("mid_first_grant", 128'(bus.grant), 128'(4'b0001));

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 5) == 0) req_drv = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                int who;
                int pos;
                logic [7:0] ch;
                who = $urandom_range(0, NREQ - 1);
                pos = $urandom_range(0, 15);
                ch  = 8'h41 + 8'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 0) r1[who][pos*8 +: 8] = ch;
                else                           r2[who][pos*8 +: 8] = ch;
            end
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
